// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
// Holds the default datapath widths, the NOP and halt encodings, the
// next-PC source encoding and clogb2(), used to size word-address buses.
package mips_pkg;

  // Ceiling log2 of a memory depth, i.e. the number of address bits
  // needed to index 'depth' entries.
  function automatic int clogb2(input int depth);
    int bits;
    bits = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return bits;
  endfunction

  localparam int          MIPS_NB_REG     = 32;
  localparam int          MIPS_NB_INSTR   = 32;
  localparam int          MIPS_N_ADDR     = 2048;
  localparam int          MIPS_NB_INM_I   = 16;
  localparam int          MIPS_NB_INM_J   = 26;
  localparam logic [31:0] MIPS_NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] MIPS_HALT_INSTR = 32'hFFFF_FFFF;

  // Next-PC source, in descending priority: jump-register, jump-immediate,
  // taken branch, sequential.
  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_BRANCH   = 2'd1,
    PC_JUMP_INM = 2'd2,
    PC_JUMP_RS  = 2'd3
  } pc_src_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: N_ADDR words of NB_INSTR bits.
// Ports:
//   i_clock  - write clock
//   i_we     - write strobe (program load)
//   i_waddr  - write word address
//   i_wdata  - write data
//   i_raddr  - read word address
//   o_rdata  - combinational read data
// A read of the word being written in the same cycle returns the old
// contents; the new word is visible after the clock edge.
module instruction_memory #(
  parameter int NB_INSTR = 32,
  parameter int N_ADDR   = 2048,
  parameter int NB_ADDR  = 11
) (
  input  logic                i_clock,
  input  logic                i_we,
  input  logic [NB_ADDR-1:0]  i_waddr,
  input  logic [NB_INSTR-1:0] i_wdata,
  input  logic [NB_ADDR-1:0]  i_raddr,
  output logic [NB_INSTR-1:0] o_rdata
);

  logic [NB_INSTR-1:0] mem [N_ADDR];

  // NOTE: the array has no reset; clearing thousands of words would need a
  // reset tree per bit, and the program loader initialises it anyway.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch_pipe.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC and the program memory, selects the next PC from
// jump-register, jump-immediate, branch or sequential sources, and feeds the
// decode stage through the IF/ID register with stall, squash-on-redirect
// and a sticky halt flag.
// Ports:
//   i_clock, i_reset        - clock, asynchronous active-low reset
//   i_valid                 - global enable (debug step); low freezes state
//   i_stall                 - hazard stall from ID: PC and IF/ID hold
//   i_jump_inm/i_jump_rs    - J/JAL and JR/JALR resolved in ID
//   i_branch                - taken branch resolved in ID
//   i_inm_i, i_inm_j, i_rs  - branch offset (words), jump index, jump target
//   i_mem_we/addr/data      - program-load write port
//   o_instruction,o_pc_plus4,o_valid - IF/ID register
//   o_pc                    - current fetch PC
//   o_halt                  - sticky halt flag
module instruction_fetch_pipe
  import mips_pkg::*;
#(
  parameter int                 NB_REG             = MIPS_NB_REG,
  parameter int                 NB_INSTR           = MIPS_NB_INSTR,
  parameter int                 N_ADDR             = MIPS_N_ADDR,
  parameter int                 LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
  parameter int                 NB_INM_I           = MIPS_NB_INM_I,
  parameter int                 NB_INM_J           = MIPS_NB_INM_J,
  parameter logic [NB_INSTR-1:0] HALT_INSTR        = NB_INSTR'(MIPS_HALT_INSTR)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic                          i_stall,
  input  logic                          i_jump_inm,
  input  logic                          i_jump_rs,
  input  logic                          i_branch,
  input  logic [NB_INM_I-1:0]           i_inm_i,
  input  logic [NB_INM_J-1:0]           i_inm_j,
  input  logic [NB_REG-1:0]             i_rs,
  input  logic                          i_mem_we,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_mem_addr,
  input  logic [NB_INSTR-1:0]           i_mem_data,
  output logic [NB_INSTR-1:0]           o_instruction,
  output logic [NB_REG-1:0]             o_pc_plus4,
  output logic                          o_valid,
  output logic [NB_REG-1:0]             o_pc,
  output logic                          o_halt
);

  localparam logic [NB_INSTR-1:0] NOP = NB_INSTR'(MIPS_NOP_INSTR);

  logic [NB_INSTR-1:0] fetched;
  logic [NB_REG-1:0]   seq_pc;
  logic [NB_REG-1:0]   branch_offset;
  logic [NB_REG-1:0]   next_pc;
  pc_src_e             pc_src;
  logic                advance;
  logic                redirect;

  // Word-indexed fetch; PC bits above the memory range are ignored, so the
  // fetch address wraps modulo the memory size.
  instruction_memory #(
    .NB_INSTR (NB_INSTR),
    .N_ADDR   (N_ADDR),
    .NB_ADDR  (LOG2_N_INSMEM_ADDR)
  ) u_instruction_memory (
    .i_clock  (i_clock),
    .i_we     (i_mem_we),
    .i_waddr  (i_mem_addr),
    .i_wdata  (i_mem_data),
    .i_raddr  (o_pc[LOG2_N_INSMEM_ADDR+1:2]),
    .o_rdata  (fetched)
  );

  // Control from ID only acts when the pipe is stepping, not stalled and not
  // halted; a redirect seen during a stall is dropped, not remembered.
  assign advance  = i_valid & ~i_stall & ~o_halt;
  assign redirect = advance & (pc_src != PC_SEQ);

  assign seq_pc        = o_pc + NB_REG'(4);
  assign branch_offset = {{(NB_REG-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    pc_src  = PC_SEQ;
    next_pc = seq_pc;
    if (i_jump_rs) begin
      pc_src = PC_JUMP_RS;
    end else if (i_jump_inm) begin
      pc_src = PC_JUMP_INM;
    end else if (i_branch) begin
      pc_src = PC_BRANCH;
    end

    unique case (pc_src)
      PC_JUMP_RS:  next_pc = i_rs;
      // Jump keeps the region bits of the jump instruction's own PC+4.
      PC_JUMP_INM: next_pc = {o_pc_plus4[NB_REG-1 -: (NB_REG-NB_INM_J-2)], i_inm_j, 2'b00};
      PC_BRANCH:   next_pc = o_pc_plus4 + branch_offset;
      default:     next_pc = seq_pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_pc          <= '0;
      o_instruction <= NOP;
      o_pc_plus4    <= '0;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
    end else if (i_valid) begin
      if (o_halt) begin
        // Halted: PC frozen, decode sees only bubbles.
        o_instruction <= NOP;
        o_pc_plus4    <= '0;
        o_valid       <= 1'b0;
      end else if (!i_stall) begin
        if (redirect) begin
          // Squash the wrong-path fetch; no delay slot. A halt fetched in
          // this cycle is on the wrong path and is not latched.
          o_pc          <= next_pc;
          o_instruction <= NOP;
          o_pc_plus4    <= '0;
          o_valid       <= 1'b0;
        end else begin
          o_pc          <= seq_pc;
          o_instruction <= fetched;
          o_pc_plus4    <= seq_pc;
          o_valid       <= 1'b1;
          o_halt        <= (fetched == HALT_INSTR);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_pipe.sv
// Self-checking bench for instruction_fetch_pipe. Each step pushes the
// expected IF/ID + PC state onto a scoreboard as stimulus is driven, and
// pops/compares it once the clock edge has produced the DUT's output.
module tb_instruction_fetch_pipe;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        tb_clock_i = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_stall;
  logic        i_jump_inm;
  logic        i_jump_rs;
  logic        i_branch;
  logic [15:0] i_inm_i;
  logic [25:0] i_inm_j;
  logic [31:0] i_rs;
  logic        i_mem_we;
  logic [10:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus4;
  logic        o_valid;
  logic [31:0] o_pc;
  logic        o_halt;

  instruction_fetch_pipe dut (
    .i_clock       (tb_clock_i),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_stall       (i_stall),
    .i_jump_inm    (i_jump_inm),
    .i_jump_rs     (i_jump_rs),
    .i_branch      (i_branch),
    .i_inm_i       (i_inm_i),
    .i_inm_j       (i_inm_j),
    .i_rs          (i_rs),
    .i_mem_we      (i_mem_we),
    .i_mem_addr    (i_mem_addr),
    .i_mem_data    (i_mem_data),
    .o_instruction (o_instruction),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_halt        (o_halt)
  );

  always #5 tb_clock_i = ~tb_clock_i;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] pc;
    logic        halt;
    bit          chk_p4;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] instr, input logic [31:0] pcp4,
                          input logic valid, input logic [31:0] pc, input logic halt);
    exp_t e;
    e.tag = tag; e.instr = instr; e.pcp4 = pcp4; e.valid = valid;
    e.pc = pc; e.halt = halt; e.chk_p4 = 1'b1;
    sb.push_back(e);
  endtask

  // Bubble: NOP with o_valid low; its PC+4 field carries no meaning.
  task automatic push_bubble(input string tag, input logic [31:0] pc, input logic halt);
    exp_t e;
    e.tag = tag; e.instr = '0; e.pcp4 = '0; e.valid = 1'b0;
    e.pc = pc; e.halt = halt; e.chk_p4 = 1'b0;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "/instr"}, o_instruction, e.instr);
    if (e.chk_p4) check({e.tag, "/pc_plus4"}, o_pc_plus4, e.pcp4);
    check({e.tag, "/valid"}, {31'b0, o_valid}, {31'b0, e.valid});
    check({e.tag, "/pc"}, o_pc, e.pc);
    check({e.tag, "/halt"}, {31'b0, o_halt}, {31'b0, e.halt});
  endtask

  task automatic tick();
    @(posedge tb_clock_i);
    #1;
  endtask

  task automatic step();
    tick();
    compare_out();
  endtask

  task automatic drive(input bit jrs, input bit ji, input bit br,
                       input logic [31:0] rs, input logic [25:0] j, input logic [15:0] imm);
    i_jump_rs  = jrs;
    i_jump_inm = ji;
    i_branch   = br;
    i_rs       = rs;
    i_inm_j    = j;
    i_inm_i    = imm;
  endtask

  task automatic load(input logic [10:0] addr, input logic [31:0] data);
    i_mem_we   = 1'b1;
    i_mem_addr = addr;
    i_mem_data = data;
    tick();
    i_mem_we   = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_stall = 1'b0;
    i_mem_we = 1'b0; i_mem_addr = '0; i_mem_data = '0;
    drive(0, 0, 0, '0, '0, '0);

    // Program image, loaded while reset is held.
    for (int k = 0; k < 5; k++) load(11'(k), 32'h2001_0001 + k);
    load(11'd5,    32'h2001_0006);
    load(11'd64,   32'hAAAA_0040);
    load(11'd65,   32'hAAAA_0041);
    load(11'd2047, 32'hCCCC_1FFC);

    push_exp("reset", 32'h0, 32'h0, 0, 32'h0, 0);
    compare_out();

    i_reset = 1'b1;
    i_valid = 1'b1;

    // Sequential fetch of words 0..3.
    push_exp("seq0", 32'h2001_0001, 32'h4,  1, 32'h4,  0); step();
    push_exp("seq1", 32'h2001_0002, 32'h8,  1, 32'h8,  0); step();
    push_exp("seq2", 32'h2001_0003, 32'hC,  1, 32'hC,  0); step();
    push_exp("seq3", 32'h2001_0004, 32'h10, 1, 32'h10, 0); step();

    // Jump-register back to 0x4 so that o_pc_plus4 reaches 0x8.
    drive(1, 0, 0, 32'h4, '0, '0);
    push_bubble("jr_bubble", 32'h4, 0); step();
    drive(0, 0, 0, '0, '0, '0);
    push_exp("jr_fetch", 32'h2001_0002, 32'h8, 1, 32'h8, 0); step();

    // Jump-immediate from PC+4 = 0x8 to 0x100.
    drive(0, 1, 0, '0, 26'h40, '0);
    push_bubble("j_bubble", 32'h100, 0); step();
    drive(0, 0, 0, '0, '0, '0);
    push_exp("j_fetch", 32'hAAAA_0040, 32'h104, 1, 32'h104, 0); step();

    // Priority: jump-register beats branch, then beats all.
    drive(1, 0, 1, 32'h20, '0, 16'h1);
    push_bubble("prio_rs_br", 32'h20, 0); step();
    drive(1, 1, 1, 32'h1FFC, 26'h3FF_FFFF, 16'h1);
    push_bubble("prio_all", 32'h1FFC, 0); step();
    drive(0, 0, 0, '0, '0, '0);

    // Last word, then wrap to word 0.
    push_exp("top_word", 32'hCCCC_1FFC, 32'h2000, 1, 32'h2000, 0); step();
    push_exp("wrap",     32'h2001_0001, 32'h2004, 1, 32'h2004, 0); step();

    // Backward branch: PC+4 = 0x10, offset -2 words -> 0x08.
    drive(1, 0, 0, 32'hC, '0, '0);
    push_bubble("jr_c", 32'hC, 0); step();
    drive(0, 0, 0, '0, '0, '0);
    push_exp("pre_br", 32'h2001_0004, 32'h10, 1, 32'h10, 0); step();
    drive(0, 0, 1, '0, '0, 16'hFFFE);
    push_bubble("br_back", 32'h8, 0); step();
    drive(0, 0, 0, '0, '0, '0);
    push_exp("br_fetch", 32'h2001_0003, 32'hC, 1, 32'hC, 0); step();

    // Stall for 3 cycles with a branch pending: nothing moves, branch dropped.
    i_stall = 1'b1;
    drive(0, 0, 1, '0, '0, 16'h10);
    for (int k = 0; k < 3; k++) begin
      push_exp("stall", 32'h2001_0003, 32'hC, 1, 32'hC, 0); step();
    end
    i_stall = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    push_exp("post_stall", 32'h2001_0004, 32'h10, 1, 32'h10, 0); step();

    // i_valid low freezes everything, but the halt word still gets written.
    i_valid = 1'b0;
    drive(0, 0, 1, '0, '0, 16'h10);
    i_mem_we = 1'b1; i_mem_addr = 11'd5; i_mem_data = HALT;
    push_exp("freeze0", 32'h2001_0004, 32'h10, 1, 32'h10, 0); step();
    i_mem_we = 1'b0;
    push_exp("freeze1", 32'h2001_0004, 32'h10, 1, 32'h10, 0); step();
    i_valid = 1'b1;
    drive(0, 0, 0, '0, '0, '0);

    // Run into the halt at word 5.
    push_exp("pre_halt", 32'h2001_0005, 32'h14, 1, 32'h14, 0); step();
    push_exp("halt",     HALT,          32'h18, 1, 32'h18, 1); step();
    drive(1, 0, 0, 32'h40, '0, '0);
    push_bubble("halted0", 32'h18, 1); step();
    push_bubble("halted1", 32'h18, 1); step();
    drive(0, 0, 0, '0, '0, '0);

    // Asynchronous reset mid-run clears everything at once.
    i_reset = 1'b0;
    #1;
    push_exp("mid_reset", 32'h0, 32'h0, 0, 32'h0, 0);
    compare_out();
    tick();
    i_reset = 1'b1;
    push_exp("restart", 32'h2001_0001, 32'h4, 1, 32'h4, 0); step();

    // A redirect in the cycle that fetches the halt word wins.
    drive(1, 0, 0, 32'h14, '0, '0);
    push_bubble("to_halt", 32'h14, 0); step();
    drive(1, 0, 0, 32'h0, '0, '0);
    push_bubble("halt_squashed", 32'h0, 0); step();
    drive(0, 0, 0, '0, '0, '0);
    push_exp("after_squash", 32'h2001_0001, 32'h4, 1, 32'h4, 0); step();

    // Same-cycle write to the fetched word returns the old contents.
    i_mem_we = 1'b1; i_mem_addr = 11'd1; i_mem_data = 32'h1234_5678;
    push_exp("wr_collide", 32'h2001_0002, 32'h8, 1, 32'h8, 0); step();
    i_mem_we = 1'b0;
    push_exp("after_wr", 32'h2001_0003, 32'hC, 1, 32'hC, 0); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
